// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between the IF fetch port and the MEM load/store port.
// Define MEM_ARB_TIMEOUT_EN to compile in the BUSY-state watchdog (TIMEOUT cycles, sticky bus_err).
module mem_port_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        if_flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_strb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_busy,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_e;

    localparam logic [31:0] AbortData = 32'hDEAD_BEEF;
    localparam logic [3:0]  StreakMax = 4'(MAX_DSTREAK);

    state_e      state_q;
    logic [3:0]  dstreak_q;
    logic        drop_q;
    logic        memReq_q;
    logic        memWe_q;
    logic [31:0] memAddr_q;
    logic [31:0] memWdata_q;
    logic [3:0]  memStrb_q;
    logic        ifRvalid_q;
    logic [31:0] ifRdata_q;
    logic        dRvalid_q;
    logic [31:0] dRdata_q;

    logic        streakFull;
    logic        grantI;
    logic        grantD;
    logic        tmoHit;
    logic        finish;

    // Data wins contention until it has taken MAX_DSTREAK contended grants in a row.
    assign streakFull = (dstreak_q == StreakMax);

    always_comb begin
        grantI = 1'b0;
        grantD = 1'b0;
        if (state_q == IDLE) begin
            if (d_req && !(if_req && streakFull)) begin
                grantD = 1'b1;
            end else if (if_req) begin
                grantI = 1'b1;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TmoW-1:0] tmoCnt_q;
    logic            busErr_q;

    assign tmoHit = (state_q != IDLE) && !mem_ack && (tmoCnt_q == TmoW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmoCnt_q <= '0;
            busErr_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                tmoCnt_q <= '0;
            end else begin
                tmoCnt_q <= tmoCnt_q + TmoW'(1);
            end
            if (tmoHit) begin
                busErr_q <= 1'b1;
            end
        end
    end

    assign bus_err = busErr_q;
`else
    // Without the watchdog TIMEOUT has no effect; the FSM waits for mem_ack forever.
    if (TIMEOUT == 0) begin : g_timeoutUnused
    end

    assign tmoHit  = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign finish = mem_ack || tmoHit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dstreak_q  <= '0;
            drop_q     <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memStrb_q  <= '0;
            ifRvalid_q <= 1'b0;
            ifRdata_q  <= '0;
            dRvalid_q  <= 1'b0;
            dRdata_q   <= '0;
        end else begin
            ifRvalid_q <= 1'b0;
            dRvalid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (grantD) begin
                        state_q    <= DBUSY;
                        memReq_q   <= 1'b1;
                        memWe_q    <= d_we;
                        memAddr_q  <= d_addr;
                        memWdata_q <= d_we ? d_wdata : '0;
                        memStrb_q  <= d_strb;
                        if (if_req && !streakFull) begin
                            dstreak_q <= dstreak_q + 4'd1;
                        end
                    end else if (grantI) begin
                        state_q    <= IBUSY;
                        memReq_q   <= 1'b1;
                        memWe_q    <= 1'b0;
                        memAddr_q  <= if_addr & 32'hFFFF_FFFC;
                        memWdata_q <= '0;
                        memStrb_q  <= '0;
                        dstreak_q  <= '0;
                        drop_q     <= if_flush;
                    end
                end
                IBUSY: begin
                    if (finish) begin
                        state_q  <= IDLE;
                        memReq_q <= 1'b0;
                        drop_q   <= 1'b0;
                        // A flush arriving with the ack still discards the response.
                        if (!(drop_q || if_flush)) begin
                            ifRvalid_q <= 1'b1;
                            ifRdata_q  <= mem_ack ? mem_rdata : AbortData;
                        end
                    end else if (if_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                DBUSY: begin
                    if (finish) begin
                        state_q   <= IDLE;
                        memReq_q  <= 1'b0;
                        dRvalid_q <= 1'b1;
                        if (!mem_ack) begin
                            dRdata_q <= AbortData;
                        end else begin
                            dRdata_q <= memWe_q ? 32'h0 : mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    memReq_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = grantI;
    assign d_gnt     = grantD;
    assign if_rvalid = ifRvalid_q;
    assign if_rdata  = ifRdata_q;
    assign d_rvalid  = dRvalid_q;
    assign d_rdata   = dRdata_q;
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_strb  = memStrb_q;
    assign mem_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected read data,
// a negedge monitor pops and compares on every rvalid pulse.
module tb_mem_port_arbiter;

    localparam int unsigned TmoCycles = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_strb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        bus_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ifQ[$];
    logic [31:0] dQ[$];
    int          memLatency = 1;
    logic [31:0] memData = '0;
    int          busyCycles = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_DSTREAK(4),
        .TIMEOUT    (TmoCycles)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_flush (if_flush),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_strb   (d_strb),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_strb (mem_strb),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .mem_busy (mem_busy),
        .bus_err  (bus_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic dReq,
                                 input logic dWe, input logic [31:0] dAddr, input logic [31:0] dWdata,
                                 input logic [3:0] dStrb, input logic flush);
        if_req   = ifReq;
        if_addr  = ifAddr;
        d_req    = dReq;
        d_we     = dWe;
        d_addr   = dAddr;
        d_wdata  = dWdata;
        d_strb   = dStrb;
        if_flush = flush;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Memory model: acks after memLatency cycles of mem_req (0 = never acks).
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #3;
            if (rst || !mem_req) begin
                busyCycles = 0;
                mem_ack    = 1'b0;
            end else begin
                busyCycles++;
                mem_ack   = (memLatency != 0) && (busyCycles == memLatency);
                mem_rdata = mem_ack ? memData : 32'h0;
            end
        end
    end

    // Monitor: every rvalid pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (if_rvalid) begin
            if (ifQ.size() == 0) checkOutput("unexpected if_rvalid", {31'b0, if_rvalid}, 32'h0);
            else                 checkOutput("if_rdata", if_rdata, ifQ.pop_front());
        end
        if (d_rvalid) begin
            if (dQ.size() == 0) checkOutput("unexpected d_rvalid", {31'b0, d_rvalid}, 32'h0);
            else                checkOutput("d_rdata", d_rdata, dQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic expI;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) nextCycle();
        checkOutput("reset mem_busy", {31'b0, mem_busy}, 32'h0);
        checkOutput("reset mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset if_rdata", if_rdata, 32'h0);
        checkOutput("reset d_rdata", d_rdata, 32'h0);
        checkOutput("reset bus_err", {31'b0, bus_err}, 32'h0);
        rst = 1'b0;
        nextCycle();

        $display("[TB] fetch 0x100, k=2");
        memLatency = 2;
        memData    = 32'h0050_0093;
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0);
        checkOutput("fetch if_gnt", {31'b0, if_gnt}, 32'h1);
        checkOutput("fetch d_gnt", {31'b0, d_gnt}, 32'h0);
        ifQ.push_back(32'h0050_0093);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fetch mem_req N+1", {31'b0, mem_req}, 32'h1);
        checkOutput("fetch mem_addr", mem_addr, 32'h100);
        checkOutput("fetch mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("fetch mem_busy", {31'b0, mem_busy}, 32'h1);
        nextCycle();
        checkOutput("fetch mem_req N+2", {31'b0, mem_req}, 32'h1);
        nextCycle();
        checkOutput("fetch if_rvalid N+3", {31'b0, if_rvalid}, 32'h1);
        checkOutput("fetch mem_req N+3", {31'b0, mem_req}, 32'h0);
        checkOutput("fetch mem_busy N+3", {31'b0, mem_busy}, 32'h0);

        $display("[TB] load 0x3000 then store 0x2000, k=1");
        memLatency = 1;
        memData    = 32'h1234_5678;
        applyStimulus(0, 0, 1, 0, 32'h3000, 32'hFFFF_FFFF, 4'hF, 0);
        checkOutput("load d_gnt", {31'b0, d_gnt}, 32'h1);
        dQ.push_back(32'h1234_5678);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("load mem_addr", mem_addr, 32'h3000);
        checkOutput("load mem_we", {31'b0, mem_we}, 32'h0);
        nextCycle();
        checkOutput("load d_rvalid", {31'b0, d_rvalid}, 32'h1);
        memData = 32'h7777_7777;
        applyStimulus(0, 0, 1, 1, 32'h2000, 32'hA5A5_A5A5, 4'b0011, 0);
        checkOutput("store d_gnt", {31'b0, d_gnt}, 32'h1);
        dQ.push_back(32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("store mem_we", {31'b0, mem_we}, 32'h1);
        checkOutput("store mem_addr", mem_addr, 32'h2000);
        checkOutput("store mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        checkOutput("store mem_strb", {28'b0, mem_strb}, 32'h3);
        checkOutput("store mem_req", {31'b0, mem_req}, 32'h1);
        nextCycle();
        checkOutput("store d_rvalid", {31'b0, d_rvalid}, 32'h1);

        $display("[TB] contended streak, expect D,D,D,D,I,D,D,D,D,I");
        for (int i = 0; i < 10; i++) begin
            expI    = (i == 4) || (i == 9);
            memData = 32'hC0DE_0000 + 32'(i);
            applyStimulus(1, 32'h400, 1, 0, 32'h5000, 0, 4'hF, 0);
            checkOutput($sformatf("streak%0d if_gnt", i), {31'b0, if_gnt}, {31'b0, expI});
            checkOutput($sformatf("streak%0d d_gnt", i), {31'b0, d_gnt}, {31'b0, !expI});
            if (expI) ifQ.push_back(memData);
            else      dQ.push_back(memData);
            nextCycle();
            if (i == 9) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("streak%0d busy gnt", i), {30'b0, if_gnt, d_gnt}, 32'h0);
            nextCycle();
        end

        $display("[TB] flush during IBUSY, k=3");
        memLatency = 3;
        memData    = 32'hBAD0_0001;
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0);
        checkOutput("flush1 if_gnt", {31'b0, if_gnt}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("flush1 mem_busy N+3", {31'b0, mem_busy}, 32'h1);
        nextCycle();
        checkOutput("flush1 mem_busy N+4", {31'b0, mem_busy}, 32'h0);
        checkOutput("flush1 if_rvalid", {31'b0, if_rvalid}, 32'h0);
        checkOutput("flush1 if_rdata held", if_rdata, 32'hC0DE_0009);

        $display("[TB] flush with ack, k=1");
        memLatency = 1;
        memData    = 32'hBAD0_0002;
        applyStimulus(1, 32'h204, 0, 0, 0, 0, 0, 0);
        checkOutput("flush2 if_gnt", {31'b0, if_gnt}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush2 if_rvalid", {31'b0, if_rvalid}, 32'h0);
        checkOutput("flush2 mem_busy", {31'b0, mem_busy}, 32'h0);

        $display("[TB] flush during DBUSY is ignored");
        memData = 32'h600D_F00D;
        applyStimulus(0, 0, 1, 0, 32'h3004, 0, 4'hF, 0);
        checkOutput("flush3 d_gnt", {31'b0, d_gnt}, 32'h1);
        dQ.push_back(32'h600D_F00D);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("flush3 d_rvalid", {31'b0, d_rvalid}, 32'h1);

        $display("[TB] flush in the fetch-grant cycle");
        memData = 32'hBAD0_0003;
        applyStimulus(1, 32'h208, 0, 0, 0, 0, 0, 1);
        checkOutput("flush4 if_gnt", {31'b0, if_gnt}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("flush4 if_rvalid", {31'b0, if_rvalid}, 32'h0);

        $display("[TB] reset in the middle of DBUSY");
        memLatency = 5;
        memData    = 32'hBAD0_0004;
        applyStimulus(0, 0, 1, 0, 32'h3008, 0, 4'hF, 0);
        checkOutput("rstmid d_gnt", {31'b0, d_gnt}, 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rstmid mem_req before", {31'b0, mem_req}, 32'h1);
        rst = 1'b1;
        nextCycle();
        checkOutput("rstmid mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rstmid mem_busy", {31'b0, mem_busy}, 32'h0);
        checkOutput("rstmid d_rvalid", {31'b0, d_rvalid}, 32'h0);
        checkOutput("rstmid d_rdata", d_rdata, 32'h0);
        checkOutput("rstmid if_rdata", if_rdata, 32'h0);
        rst = 1'b0;
        repeat (6) nextCycle();

`ifdef MEM_ARB_TIMEOUT_EN
        $display("[TB] watchdog abort, memory never acks");
        memLatency = 0;
        applyStimulus(0, 0, 1, 0, 32'h300C, 0, 4'hF, 0);
        checkOutput("tmo d_gnt", {31'b0, d_gnt}, 32'h1);
        dQ.push_back(32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (7) nextCycle();
        checkOutput("tmo mem_req N+8", {31'b0, mem_req}, 32'h1);
        nextCycle();
        checkOutput("tmo mem_req N+9", {31'b0, mem_req}, 32'h0);
        checkOutput("tmo d_rvalid", {31'b0, d_rvalid}, 32'h1);
        checkOutput("tmo bus_err", {31'b0, bus_err}, 32'h1);
        repeat (3) nextCycle();
        checkOutput("tmo bus_err sticky", {31'b0, bus_err}, 32'h1);
        rst = 1'b1;
        nextCycle();
        checkOutput("tmo bus_err reset", {31'b0, bus_err}, 32'h0);
        rst = 1'b0;
        memLatency = 1;
`else
        checkOutput("bus_err tied low", {31'b0, bus_err}, 32'h0);
`endif

        repeat (3) nextCycle();
        checkOutput("ifQ drained", 32'(ifQ.size()), 32'h0);
        checkOutput("dQ drained", 32'(dQ.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
